div_unit: RTL and testbench

- Iterative 32-bit divider for the EX stage; services DIV/DIVU.
- Acts as responder to EX: EX raises a start request, the divider answers with a ready/result handshake.
- The 64-bit result splits into hi = remainder and lo = quotient.
- EX forwards the split result as its hi/lo write bundle with whilo asserted. EX stalls the pipeline while a division is in flight.

---
 rtl/div_unit_pkg.sv | 31 +++
 rtl/div_unit_if.sv | 34 +++
 rtl/div_unit.sv | 169 ++++++++++++++++
 tb/tb_div_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared types and constants for the iterative divider
//               (state encoding, handshake levels, double-word helpers).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

  // Divider state encoding (2-bit codes)
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Handshake levels
  localparam logic c_div_result_ready     = 1'b1;
  localparam logic c_div_result_not_ready = 1'b0;
  localparam logic c_div_start            = 1'b1;
  localparam logic c_div_stop             = 1'b0;

  // Double register bus (hi:lo) and its zero value
  typedef logic [63:0] double_reg_bus_t;
  localparam double_reg_bus_t c_zero_double_word = 64'd0;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
// Module      : div_unit_if
// Description : EX <-> divider request/response bundle. EX is the master
//               (raises start, supplies operands); the divider is the slave
//               (returns ready and the {remainder, quotient} result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_if #(
  parameter int WIDTH = 32
) ();

  logic                 signed_div;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 start;
  logic                 annul;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready
  );

endinterface : div_unit_if

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Iterative restoring divider for DIV/DIVU. One quotient bit
//               per clock; result = {remainder (hi), quotient (lo)}.
//               Optional macro DIV_FAST_SMALL_EN: when |dividend| < |divisor|
//               the answer (quotient 0, remainder = dividend) is produced
//               straight from FREE without iterating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam logic [5:0] c_cnt_done = 6'(WIDTH);

  div_state_e           r_state,     w_state_nxt;
  logic [5:0]           r_cnt,       w_cnt_nxt;
  logic [2*WIDTH:0]     r_dividend,  w_dividend_nxt;
  logic [WIDTH-1:0]     r_divisor,   w_divisor_nxt;
  logic                 r_dvd_neg,   w_dvd_neg_nxt;
  logic                 r_quot_neg,  w_quot_neg_nxt;
  logic [2*WIDTH-1:0]   r_result,    w_result_nxt;
  logic                 r_ready,     w_ready_nxt;

  logic [WIDTH-1:0]     w_op1_mag;
  logic [WIDTH-1:0]     w_op2_mag;
  logic                 w_fast_small;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Operand magnitudes: negate only in signed mode when the MSB is set
  assign w_op1_mag = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
  assign w_op2_mag = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

`ifdef DIV_FAST_SMALL_EN
  assign w_fast_small = (w_op1_mag < w_op2_mag);
`else
  assign w_fast_small = 1'b0;
`endif

  // The partial remainder plus the next dividend bit needs WIDTH+1 bits, since
  // the remainder can reach divisor-1 with its top bit set. When the trial
  // succeeds the true difference is below 2^WIDTH, so a WIDTH-bit modular
  // subtract of the low bits is exact.
  assign w_fits = (r_dividend[2*WIDTH:WIDTH] >= {1'b0, r_divisor});
  assign w_diff = r_dividend[2*WIDTH-1:WIDTH] - r_divisor;

  // Quotient collects in the low bits, remainder in the top WIDTH bits
  assign w_quot     = r_dividend[WIDTH-1:0];
  assign w_rem      = r_dividend[2*WIDTH:WIDTH+1];
  assign w_quot_fix = r_quot_neg ? -w_quot : w_quot;
  assign w_rem_fix  = r_dvd_neg  ? -w_rem  : w_rem;

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_dvd_neg_nxt  = r_dvd_neg;
    w_quot_neg_nxt = r_quot_neg;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;

    case (r_state)
      DIV_FREE: begin
        w_ready_nxt  = c_div_result_not_ready;
        w_result_nxt = c_zero_double_word;
        if (bus.start == c_div_start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            w_state_nxt = DIV_BY_ZERO;
          end else if (w_fast_small) begin
            w_state_nxt  = DIV_END;
            w_result_nxt = {bus.opdata1, {WIDTH{1'b0}}};
            w_ready_nxt  = c_div_result_ready;
          end else begin
            w_state_nxt    = DIV_ON;
            w_cnt_nxt      = 6'd0;
            w_dividend_nxt = {{WIDTH{1'b0}}, w_op1_mag, 1'b0};
            w_divisor_nxt  = w_op2_mag;
            w_dvd_neg_nxt  = bus.signed_div & bus.opdata1[WIDTH-1];
            w_quot_neg_nxt = bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
          end
        end
      end

      DIV_BY_ZERO: begin
        w_dividend_nxt = '0;
        w_state_nxt    = DIV_END;
        w_result_nxt   = c_zero_double_word;
        w_ready_nxt    = c_div_result_ready;
      end

      DIV_ON: begin
        if (bus.annul) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = 6'd0;
          w_ready_nxt  = c_div_result_not_ready;
          w_result_nxt = c_zero_double_word;
        end else if (r_cnt != c_cnt_done) begin
          if (w_fits) begin
            w_dividend_nxt = {w_diff, r_dividend[WIDTH-1:0], 1'b1};
          end else begin
            w_dividend_nxt = {r_dividend[2*WIDTH-1:0], 1'b0};
          end
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          w_state_nxt  = DIV_END;
          w_cnt_nxt    = 6'd0;
          w_result_nxt = {w_rem_fix, w_quot_fix};
          w_ready_nxt  = c_div_result_ready;
        end
      end

      DIV_END: begin
        if (bus.start == c_div_stop) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = c_div_result_not_ready;
          w_result_nxt = c_zero_double_word;
        end
      end

      default: begin
        w_state_nxt = DIV_FREE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= 6'd0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_dvd_neg  <= 1'b0;
      r_quot_neg <= 1'b0;
      r_result   <= c_zero_double_word;
      r_ready    <= c_div_result_not_ready;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_dvd_neg  <= w_dvd_neg_nxt;
      r_quot_neg <= w_quot_neg_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign bus.result = r_result;
  assign bus.ready  = r_ready;

endmodule : div_unit

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Scoreboard bench for div_unit. The driver pushes the expected
//               result and latency for each request; a monitor pops and
//               compares on every rising edge of ready, and checks the result
//               is held while ready stays high and cleared when it drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          k;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  // Reference quotient/remainder from plain 64-bit arithmetic (truncating division)
  function automatic logic [63:0] ref_div(bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Edges from the start-sampling edge until ready is first seen high
  function automatic int ref_lat(bit sgn, logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return 1;
`ifdef DIV_FAST_SMALL_EN
    begin
      longint ma, mb;
      ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 0;
    end
`endif
    return 33;
  endfunction

  // Edge counter
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: compares against the scoreboard whenever the DUT presents a result
  initial begin
    logic        prev_ready;
    logic [63:0] held;
    exp_t        e;
    prev_ready = 1'b0;
    held       = 64'd0;
    forever begin
      @(negedge clk);
      if (bus.ready === 1'b1 && !prev_ready) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ready: result=%h with no request pending (cyc %0d)", bus.result, cyc);
        end else begin
          e = sb_q.pop_front();
          tests++;
          if (bus.result !== e.res) begin
            fails++;
            $display("FAIL result: got %h expected %h", bus.result, e.res);
          end
          tests++;
          if (cyc - e.k != e.lat) begin
            fails++;
            $display("FAIL latency: got %0d expected %0d", cyc - e.k, e.lat);
          end
          held = e.res;
        end
      end else if (bus.ready === 1'b1 && prev_ready) begin
        tests++;
        if (bus.result !== held) begin
          fails++;
          $display("FAIL hold: got %h expected %h", bus.result, held);
        end
      end else if (bus.ready !== 1'b1 && prev_ready) begin
        tests++;
        if (bus.result !== 64'd0) begin
          fails++;
          $display("FAIL clear: got %h expected 0", bus.result);
        end
      end
      prev_ready = (bus.ready === 1'b1);
    end
  end

  // Raise start, wait for ready (bounded), hold, then release and check ready drops
  task automatic issue(bit sgn, logic [31:0] a, logic [31:0] b, int hold, bit rst_in_end);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    e.res = ref_div(sgn, a, b);
    e.lat = ref_lat(sgn, a, b);
    e.k   = cyc + 1;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ready !== 1'b1 && n < 60);
    if (bus.ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL timeout: ready=%b after %0d cycles for %h/%h", bus.ready, n, a, b);
      sb_q.delete();
    end
    repeat (hold) @(negedge clk);
    if (rst_in_end) rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
      fails++;
      $display("FAIL release: ready=%b result=%h expected ready=0 result=0", bus.ready, bus.result);
    end
  endtask

  // Start a division that must never complete, then kill it by annul or reset
  task automatic abort_run(logic [31:0] a, logic [31:0] b, int iters, bit use_rst);
    int seen;
    @(negedge clk);
    bus.signed_div = 1'b0;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    repeat (iters + 1) @(negedge clk);
    if (use_rst) begin
      rst       = 1'b1;
      bus.start = 1'b0;
    end else begin
      bus.annul = 1'b1;
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    tests++;
    if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
      fails++;
      $display("FAIL abort_outputs: ready=%b result=%h expected 0/0", bus.ready, bus.result);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_no_ready: ready high %0d cycles expected 0", seen);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;
    rst            = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd0;
    bus.opdata2    = 32'd0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
      fails++;
      $display("FAIL reset_state: ready=%b result=%h expected 0/0", bus.ready, bus.result);
    end
    rst = 1'b0;

    issue(1'b0, 32'd100,        32'd7,          3, 1'b0);
    issue(1'b1, 32'hFFFFFFF9,   32'd2,          1, 1'b0);
    issue(1'b1, 32'd7,          32'hFFFFFFFE,   0, 1'b0);
    issue(1'b0, 32'd5,          32'd0,          2, 1'b0);
    issue(1'b1, 32'h80000000,   32'hFFFFFFFF,   1, 1'b0);
    issue(1'b1, 32'd0,          32'd5,          0, 1'b0);
    issue(1'b0, 32'd3,          32'd10,         0, 1'b0);
    issue(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   0, 1'b0);
    issue(1'b0, 32'hFFFFFFFF,   32'h80000001,   0, 1'b0);

    abort_run(32'd1000, 32'd3, 10, 1'b0);
    issue(1'b0, 32'hFFFFFFFF,   32'd1,          1, 1'b0);

    abort_run(32'd1234, 32'd5, 15, 1'b1);
    issue(1'b0, 32'd50,         32'd6,          2, 1'b1);
    issue(1'b0, 32'd9,          32'd3,          0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 20));
      issue(sgn, a, b, int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (2) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results outstanding expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_div_unit

`default_nettype wire
